// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock-qualification sequencer running on the free-running 74.25 MHz reference.
// Optional macro PLL_RETRY_EN: re-pulse pll_rst when lock does not arrive within RETRY_TIMEOUT_CYCLES.
module pll_reset_sequencer #(
  parameter int CNT_W                = 20,
  parameter int PLL_RST_CYCLES       = 16,
  parameter int LOCK_STABLE_CYCLES   = 74250,
  parameter int RELEASE_CYCLES       = 7425,
  parameter int RETRY_TIMEOUT_CYCLES = 742500
) (
  input  logic       clk_74a,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       core_reset_req,
  output logic       pll_rst,
  output logic       core_reset_n,
  output logic       pll_ready,
  output logic [7:0] lock_loss_count,
  output logic [3:0] retry_count
);

  typedef enum logic [2:0] {
    POR_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST    = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  // Every terminal count must fit in the counter, otherwise a state could never exit.
  if (PLL_RST_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 || RELEASE_CYCLES < 1 ||
      RETRY_TIMEOUT_CYCLES < 1 ||
      longint'(PLL_RST_CYCLES) >= (longint'(1) << CNT_W) ||
      longint'(LOCK_STABLE_CYCLES) >= (longint'(1) << CNT_W) ||
      longint'(RELEASE_CYCLES) >= (longint'(1) << CNT_W) ||
      longint'(RETRY_TIMEOUT_CYCLES) >= (longint'(1) << CNT_W)) begin : g_param_err
    $error("pll_reset_sequencer: cycle count parameter out of range for CNT_W");
  end

  // Reset: asynchronous assertion, deassertion released through two flops.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  logic [1:0] lock_sync;
  logic       locked_s;

  always_ff @(posedge clk_74a or negedge rst_int_n) begin
    if (!rst_int_n) lock_sync <= 2'b00;
    else            lock_sync <= {lock_sync[0], pll_locked};
  end

  assign locked_s = lock_sync[1];

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             loss_inc;
`ifdef PLL_RETRY_EN
  localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_TIMEOUT_CYCLES - 1);
  logic             retry_inc;
`endif

  always_comb begin
    state_next = state;
    loss_inc   = 1'b0;
`ifdef PLL_RETRY_EN
    retry_inc  = 1'b0;
`endif
    case (state)
      POR_RST: begin
        if (cnt == RST_LAST) state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) state_next = STABLE;
`ifdef PLL_RETRY_EN
        else if (cnt == RETRY_LAST) begin
          state_next = POR_RST;
          retry_inc  = 1'b1;
        end
`endif
      end
      STABLE: begin
        if (!locked_s)               state_next = WAIT_LOCK;
        else if (cnt == STABLE_LAST) state_next = RELEASE;
      end
      RELEASE: begin
        if (!locked_s)            state_next = WAIT_LOCK;
        else if (cnt == REL_LAST) state_next = RUN;
      end
      RUN: begin
        // Lock loss takes priority over a simultaneous soft reset request.
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          loss_inc   = 1'b1;
        end else if (core_reset_req) begin
          state_next = RELEASE;
        end
      end
      default: state_next = POR_RST;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk_74a or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state           <= POR_RST;
      cnt             <= '0;
      pll_rst         <= 1'b1;
      core_reset_n    <= 1'b0;
      pll_ready       <= 1'b0;
      lock_loss_count <= 8'd0;
    end else begin
      state        <= state_next;
      pll_rst      <= (state_next == POR_RST);
      core_reset_n <= (state_next == RUN);
      pll_ready    <= (state_next == RUN);
      if (state_next != state) cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      if (loss_inc && lock_loss_count != 8'hff)
        lock_loss_count <= lock_loss_count + 8'd1;
    end
  end

`ifdef PLL_RETRY_EN
  always_ff @(posedge clk_74a or negedge rst_int_n) begin
    if (!rst_int_n)                           retry_count <= 4'd0;
    else if (retry_inc && retry_count != 4'hf) retry_count <= retry_count + 4'd1;
  end
`else
  assign retry_count = 4'd0;
`endif

endmodule
